// File: rtl/data_if_pkg.sv
// data_if_pkg: shared constants for the host-side bus transmitter.
//   - DATA_W_DEFAULT : default bus / payload word width
//   - IDLE/HDR/OP/DATA : transmitter FSM state encodings (state_t)
//   - OP_LOAD/OP_READ  : opcode values carried in the low nibble of the operation word
package data_if_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t HDR  = 2'd1;
  localparam state_t OP   = 2'd2;
  localparam state_t DATA = 2'd3;

  localparam logic [3:0] OP_LOAD = 4'd2;
  localparam logic [3:0] OP_READ = 4'd3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock payload FIFO with a look-ahead view of its head.
// Ports:
//   clk, clear_n        clock, asynchronous active-low reset (flushes pointers/count)
//   push, wr_data       write request and word (ignored while full)
//   pop                 read request (ignored while empty)
//   full, empty         current occupancy flags
//   head_nxt            word that will be at the head after this clock edge
//   empty_nxt           FIFO will be empty after this clock edge
// FIFO_DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_nxt,
  output logic              empty_nxt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_nxt;
  logic [AW:0]       count;
  logic [AW:0]       cnt_after_pop;
  logic [AW:0]       cnt_nxt;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign rd_nxt        = rd_ptr + AW'(pop_ok);
  assign cnt_after_pop = count - (AW+1)'(pop_ok);
  assign cnt_nxt       = cnt_after_pop + (AW+1)'(push_ok);
  assign empty_nxt     = (cnt_nxt == '0);

  // When nothing older survives the pop, the word being written this cycle
  // becomes the new head, so it is forwarded straight from wr_data.
  assign head_nxt = (push_ok && cnt_after_pop == '0) ? wr_data : mem[rd_nxt];

  // Storage array; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/data_sender.sv
// data_sender: host-side transmitter for the controller's 32-bit input bus.
// Serialises a command and its buffered payload as: count word N, operation
// word, N data words, on the tx_data/tx_enable pair with tx_ready handshake.
// Ports:
//   clk, clear_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_op (low nibble = opcode), cmd_len = N
//   wr_valid/wr_ready, wr_data    payload FIFO write port (wr_ready = not full)
//   tx_data, tx_enable, tx_ready  bus word, valid, receiver ready (registered outputs)
//   busy                          transmitter not idle (or response outstanding)
//   pkt_done                      one-cycle pulse after the last data word transfers
//   cmd_err                       one-cycle pulse after a rejected command (len 0 or op 0)
// Optional build macro RESP_TRACK_EN adds rx_y_valid, rx_out_count_valid,
// rx_out_count and resp_done, holding off new commands until the response
// word count has been consumed.
module data_sender
  import data_if_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_op,
  input  logic [DATA_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_enable,
  input  logic              tx_ready,
  output logic              busy,
  output logic              pkt_done,
  output logic              cmd_err
`ifdef RESP_TRACK_EN
  ,
  input  logic              rx_y_valid,
  input  logic              rx_out_count_valid,
  input  logic [DATA_W-1:0] rx_out_count,
  output logic              resp_done
`endif
);

  state_t            state;
  logic              alive;
  logic [DATA_W-1:0] op_q;
  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] remaining;
  logic              cmd_fire;
  logic              cmd_legal;
  logic              tx_fire;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_empty_nxt;
  logic [DATA_W-1:0] fifo_head_nxt;
  logic              resp_block;

  assign cmd_ready = alive & (state == IDLE) & ~resp_block;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign cmd_legal = (cmd_len != '0) && (cmd_op != '0);
  assign tx_fire   = tx_enable & tx_ready;
  assign wr_ready  = alive & ~fifo_full;
  assign fifo_push = wr_valid & wr_ready;
  assign fifo_pop  = (state == DATA) & tx_fire & ~fifo_empty;

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clear_n   (clear_n),
    .push      (fifo_push),
    .wr_data   (wr_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_nxt  (fifo_head_nxt),
    .empty_nxt (fifo_empty_nxt)
  );

  // Keeps both handshakes low while in reset and for the release edge,
  // so nothing is accepted until the first clock after clear_n rises.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Packet sequencer. The bus registers are loaded with the value for the
  // state being entered, so each word is on the bus the cycle after the
  // decision and simply holds while tx_ready is low.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      op_q      <= '0;
      len_q     <= '0;
      remaining <= '0;
      tx_data   <= '0;
      tx_enable <= 1'b0;
      pkt_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_legal) begin
              op_q      <= cmd_op;
              len_q     <= cmd_len;
              tx_data   <= cmd_len;
              tx_enable <= 1'b1;
              state     <= HDR;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (tx_fire) begin
            tx_data <= op_q;
            state   <= OP;
          end
        end
        OP: begin
          if (tx_fire) begin
            remaining <= len_q;
            tx_enable <= ~fifo_empty_nxt;
            tx_data   <= fifo_empty_nxt ? '0 : fifo_head_nxt;
            state     <= DATA;
          end
        end
        DATA: begin
          if (tx_fire && remaining == DATA_W'(1)) begin
            remaining <= '0;
            tx_enable <= 1'b0;
            tx_data   <= '0;
            pkt_done  <= 1'b1;
            state     <= IDLE;
          end else begin
            // Stalled on an empty FIFO, the next written word is picked up
            // through the look-ahead head and presented one cycle later.
            if (tx_fire) begin
              remaining <= remaining - DATA_W'(1);
            end
            tx_enable <= ~fifo_empty_nxt;
            tx_data   <= fifo_empty_nxt ? '0 : fifo_head_nxt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RESP_TRACK_EN
  logic [DATA_W-1:0] resp_cnt;
  logic              resp_armed;
  logic              resp_pending;

  // Response tracker: a packet stays outstanding from command accept until
  // the receiver's announced output word count has been counted down.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      resp_cnt     <= '0;
      resp_armed   <= 1'b0;
      resp_pending <= 1'b0;
      resp_done    <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (cmd_fire && cmd_legal) begin
        resp_pending <= 1'b1;
      end
      if (rx_out_count_valid) begin
        if (rx_out_count == '0) begin
          resp_armed   <= 1'b0;
          resp_pending <= 1'b0;
          resp_done    <= 1'b1;
        end else begin
          resp_cnt   <= rx_out_count;
          resp_armed <= 1'b1;
        end
      end else if (resp_armed && rx_y_valid) begin
        resp_cnt <= resp_cnt - DATA_W'(1);
        if (resp_cnt == DATA_W'(1)) begin
          resp_armed   <= 1'b0;
          resp_pending <= 1'b0;
          resp_done    <= 1'b1;
        end
      end
    end
  end

  assign resp_block = resp_pending;
  assign busy       = (state != IDLE) | resp_pending;
`else
  assign resp_block = 1'b0;
  assign busy       = (state != IDLE);
`endif

endmodule

// File: tb/tb_data_sender.sv
// tb_data_sender: directed, table-driven bench for data_sender (default build).
module tb_data_sender;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op;
  logic [31:0] cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [31:0] tx_data;
  logic        tx_enable;
  logic        tx_ready;
  logic        busy;
  logic        pkt_done;
  logic        cmd_err;

  data_sender #(
    .DATA_W     (32),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .tx_data   (tx_data),
    .tx_enable (tx_enable),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // One row: inputs driven for a cycle, outputs expected after that edge.
  typedef struct {
    logic        cv;
    logic [31:0] op;
    logic [31:0] len;
    logic        wv;
    logic [31:0] wd;
    logic        rdy;
    logic        en;
    logic [31:0] data;
    logic        done;
    logic        err;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];
  int   check_count = 0;
  int   pass_count  = 0;

  function automatic vec_t mk(input logic cv, input logic [31:0] op, input logic [31:0] len,
                              input logic wv, input logic [31:0] wd, input logic rdy,
                              input logic en, input logic [31:0] data, input logic done,
                              input logic err, input logic bsy);
    vec_t v;
    v.cv = cv; v.op = op; v.len = len; v.wv = wv; v.wd = wd; v.rdy = rdy;
    v.en = en; v.data = data; v.done = done; v.err = err; v.bsy = bsy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cmd_valid = v.cv;
    cmd_op    = v.op;
    cmd_len   = v.len;
    wr_valid  = v.wv;
    wr_data   = v.wd;
    tx_ready  = v.rdy;
  endtask

  task automatic idleInputs();
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    tx_ready  = 1'b1;
  endtask

  task automatic expectBus(input string name, input logic en, input logic [31:0] data);
    checkOutput({name, ".en"}, tx_enable, en);
    if (en) checkOutput({name, ".data"}, tx_data, data);
  endtask

  task automatic sendCmd(input logic [31:0] op, input logic [31:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic writeWord(input logic [31:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idleInputs();
    clear_n = 1'b0;
    tick();
    tick();
    checkOutput("rst.tx_enable", tx_enable, 0);
    checkOutput("rst.tx_data", tx_data, 0);
    checkOutput("rst.pkt_done", pkt_done, 0);
    checkOutput("rst.cmd_err", cmd_err, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.cmd_ready", cmd_ready, 0);
    checkOutput("rst.wr_ready", wr_ready, 0);
    clear_n = 1'b1;
    tick();
    checkOutput("rel.cmd_ready", cmd_ready, 1);
    checkOutput("rel.wr_ready", wr_ready, 1);

    // Basic packet: preload A,B,C then op=2 len=3, ready always high.
    vecs.push_back(mk(0, 0, 0, 1, 32'hA, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hB, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hC, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 3, 0, 0, 1, 1, 3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hA, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hB, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hC, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Same packet with tx_ready low for three cycles while op is on the bus.
    vecs.push_back(mk(0, 0, 0, 1, 32'hA, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hB, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hC, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 3, 0, 0, 1, 1, 3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hA, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hB, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'hC, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Rejected commands: len=0, then op=0.
    vecs.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d.en", i), tx_enable, vecs[i].en);
      if (vecs[i].en) checkOutput($sformatf("vec%0d.data", i), tx_data, vecs[i].data);
      checkOutput($sformatf("vec%0d.done", i), pkt_done, vecs[i].done);
      checkOutput($sformatf("vec%0d.err", i), cmd_err, vecs[i].err);
      checkOutput($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
    end
    idleInputs();

    // Empty FIFO: len=2, data written five cycles after accept.
    sendCmd(32'h3, 32'd2);
    expectBus("empty.c1", 1, 32'd2);
    tick(); expectBus("empty.c2", 1, 32'h3);
    tick(); expectBus("empty.c3", 0, 0);
    tick(); expectBus("empty.c4", 0, 0);
    checkOutput("empty.busy", busy, 1);
    tick(); expectBus("empty.c5", 0, 0);
    wr_valid = 1'b1; wr_data = 32'h11;
    tick(); expectBus("empty.c6", 1, 32'h11);
    wr_data = 32'h22;
    tick(); expectBus("empty.c7", 1, 32'h22);
    wr_valid = 1'b0;
    tick(); expectBus("empty.c8", 0, 0);
    checkOutput("empty.done", pkt_done, 1);

    // Full FIFO: 16 writes, 17th refused, then drain in order.
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("fill%0d.wr_ready", i), wr_ready, 1);
      writeWord(32'h100 + i);
    end
    checkOutput("full.wr_ready", wr_ready, 0);
    wr_valid = 1'b1; wr_data = 32'hDEAD;
    tick(); checkOutput("full.hold1", wr_ready, 0);
    tick(); checkOutput("full.hold2", wr_ready, 0);
    wr_valid = 1'b0;
    sendCmd(32'h2, 32'd16);
    expectBus("drain.cnt", 1, 32'd16);
    tick(); expectBus("drain.op", 1, 32'h2);
    for (int k = 0; k < 16; k++) begin
      tick(); expectBus($sformatf("drain.w%0d", k), 1, 32'h100 + k);
    end
    tick(); expectBus("drain.end", 0, 0);
    checkOutput("drain.done", pkt_done, 1);
    // The refused word must not have entered the FIFO.
    sendCmd(32'h3, 32'd1);
    expectBus("after.cnt", 1, 32'd1);
    tick(); expectBus("after.op", 1, 32'h3);
    tick(); expectBus("after.stall1", 0, 0);
    tick(); expectBus("after.stall2", 0, 0);
    writeWord(32'h55);
    expectBus("after.w", 1, 32'h55);
    tick(); checkOutput("after.done", pkt_done, 1);

    // Reset in the middle of DATA.
    writeWord(32'h77);
    writeWord(32'h88);
    sendCmd(32'h2, 32'd3);
    expectBus("mid.cnt", 1, 32'd3);
    tick(); expectBus("mid.op", 1, 32'h2);
    tick(); expectBus("mid.w0", 1, 32'h77);
    #2 clear_n = 1'b0;
    #1;
    checkOutput("mid.async_en", tx_enable, 0);
    checkOutput("mid.busy", busy, 0);
    checkOutput("mid.cmd_ready", cmd_ready, 0);
    tick();
    clear_n = 1'b1;
    tick();
    checkOutput("mid.rel_ready", cmd_ready, 1);
    writeWord(32'h99);
    sendCmd(32'h2, 32'd1);
    expectBus("fresh.cnt", 1, 32'd1);
    tick(); expectBus("fresh.op", 1, 32'h2);
    tick(); expectBus("fresh.w", 1, 32'h99);
    tick(); expectBus("fresh.end", 0, 0);
    checkOutput("fresh.done", pkt_done, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
